// File: rtl/mul_operand_packer_bf16.sv
// rtl/mul_operand_packer_bf16.sv - serial bf16 operand packer feeding the six-slot multiply chain
//
// Accepts bf16 operands one per cycle, places each into its lane of a 192-bit
// word using a per-mode lane map and issues the word with a one-cycle strobe.
// A mode change is held off until the chain has drained; a partial group can
// be flushed, with its remaining used lanes padded with PAD_VALUE.
//
// Ports:
//   clk, rst      clock; asynchronous active-low reset
//   op_in         bf16 operand, qualified by op_valid / op_ready
//   mode_in       mode for the group started by the next accepted operand
//   flush         issue the current partial group, padded
//   mul_ins       packed operands to the chain (registered, held between issues)
//   mul_stb       one-cycle issue strobe (registered)
//   mode          mode of the last issued or currently filling group
//   busy          a group is filling or the chain is still draining
module mul_operand_packer_bf16 #(
   parameter int unsigned DRAIN_CYCLES = 18,
   parameter logic [15:0] PAD_VALUE    = 16'h3F80
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [15:0]  op_in,
   input  logic         op_valid,
   output logic         op_ready,
   input  logic [1:0]   mode_in,
   input  logic         flush,
   output logic [191:0] mul_ins,
   output logic         mul_stb,
   output logic [1:0]   mode,
   output logic         busy
);

   localparam int unsigned DW = $clog2(DRAIN_CYCLES + 1);
   localparam logic [DW-1:0] DCNT_LOAD = DW'(DRAIN_CYCLES);

   // Lane maps, entry k (LSB first) is the lane of the k-th operand of a group.
   localparam logic [11:0][3:0] MAP_00 = {4'd10, 4'd11, 4'd8, 4'd9, 4'd6, 4'd7,
                                          4'd4,  4'd5,  4'd2, 4'd3, 4'd0, 4'd1};
   localparam logic [11:0][3:0] MAP_01 = {4'd0,  4'd0,  4'd0, 4'd10, 4'd8, 4'd9,
                                          4'd6,  4'd4,  4'd5, 4'd2,  4'd0, 4'd1};
   localparam logic [11:0][3:0] MAP_10 = {4'd0,  4'd0,  4'd0, 4'd0, 4'd10, 4'd8,
                                          4'd6,  4'd7,  4'd4, 4'd2, 4'd0,  4'd1};
   localparam logic [11:0][3:0] MAP_11 = {4'd0,  4'd0,  4'd0, 4'd0, 4'd0, 4'd0,
                                          4'd8,  4'd6,  4'd4, 4'd2, 4'd0, 4'd1};
   localparam logic [3:0][11:0][3:0] LANE_MAP = {MAP_11, MAP_10, MAP_01, MAP_00};

   function automatic logic [3:0] group_len(input logic [1:0] m);
      logic [3:0] n;
      case (m)
         2'b00:   n = 4'd12;
         2'b01:   n = 4'd9;
         2'b10:   n = 4'd8;
         default: n = 4'd6;
      endcase
      return n;
   endfunction

   typedef enum logic [1:0] {S_EMPTY, S_FILL, S_DRAIN} state_t;

   state_t          state, state_nxt;
   logic [191:0]    asm_buf, buf_nxt;
   logic [3:0]      k, k_post, n_act;
   logic [DW-1:0]   dcnt;
   logic [1:0]      act_mode, mode_nxt;
   logic            accept, issue, flush_issue;

   always_comb begin
      state_nxt   = state;
      op_ready    = 1'b0;
      act_mode    = mode;
      mode_nxt    = mode;
      k_post      = k;
      buf_nxt     = asm_buf;
      accept      = 1'b0;
      flush_issue = 1'b0;
      issue       = 1'b0;

      unique case (state)
         // DRAIN shares the readiness test with EMPTY so that the first
         // new-mode operand is taken in the very cycle dcnt reaches zero.
         S_EMPTY, S_DRAIN: begin
            op_ready = (mode_in == mode) || (dcnt == '0);
            act_mode = mode_in;
         end
         S_FILL: begin
            op_ready    = 1'b1;
            flush_issue = flush;
         end
         default: ;
      endcase

      n_act  = group_len(act_mode);
      accept = op_valid && op_ready;

      if (accept) begin
         k_post = k + 4'd1;
         mode_nxt = act_mode;
         buf_nxt[{LANE_MAP[act_mode][k], 4'b0000} +: 16] = op_in;
      end

      issue = (accept && (k_post == n_act)) || flush_issue;

      // Padding is applied after the same-cycle operand has been placed.
      if (flush_issue) begin
         for (int j = 0; j < 12; j++) begin
            if ((4'(j) >= k_post) && (4'(j) < n_act))
               buf_nxt[{LANE_MAP[act_mode][4'(j)], 4'b0000} +: 16] = PAD_VALUE;
         end
      end

      if (issue)
         state_nxt = S_EMPTY;
      else if (accept || (state == S_FILL))
         state_nxt = S_FILL;
      else if (!op_ready)
         state_nxt = S_DRAIN;
      else
         state_nxt = S_EMPTY;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_EMPTY;
         asm_buf <= '0;
         k       <= '0;
         dcnt    <= '0;
         mode    <= 2'b00;
         mul_ins <= '0;
         mul_stb <= 1'b0;
      end else begin
         state   <= state_nxt;
         mode    <= mode_nxt;
         mul_stb <= issue;
         if (issue) begin
            mul_ins <= buf_nxt;
            asm_buf <= '0;
            k       <= '0;
            dcnt    <= DCNT_LOAD;
         end else begin
            asm_buf <= buf_nxt;
            k       <= k_post;
            if (dcnt != '0)
               dcnt <= dcnt - DW'(1);
         end
      end
   end

   assign busy = (k != '0) || (dcnt != '0);

endmodule

// File: tb/tb_mul_operand_packer_bf16.sv
// tb/tb_mul_operand_packer_bf16.sv - directed self-checking bench for mul_operand_packer_bf16
module tb_mul_operand_packer_bf16;

   logic         clk;
   logic         rst;
   logic [15:0]  op_in;
   logic         op_valid;
   logic         op_ready;
   logic [1:0]   mode_in;
   logic         flush;
   logic [191:0] mul_ins;
   logic         mul_stb;
   logic [1:0]   mode;
   logic         busy;

   int vectors;
   int miscompares;
   int stb_total;
   int stb_base;
   int low_cnt;
   logic [191:0] exp_word;

   mul_operand_packer_bf16 #(
      .DRAIN_CYCLES(18),
      .PAD_VALUE(16'h3F80)
   ) dut (
      .clk(clk),
      .rst(rst),
      .op_in(op_in),
      .op_valid(op_valid),
      .op_ready(op_ready),
      .mode_in(mode_in),
      .flush(flush),
      .mul_ins(mul_ins),
      .mul_stb(mul_stb),
      .mode(mode),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mul_stb === 1'b1)
         stb_total <= stb_total + 1;
   end

   task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one operand and holds it until accepted (bounded wait).
   task automatic send(input logic [15:0] v, input logic [1:0] m);
      int w;
      op_in    = v;
      mode_in  = m;
      op_valid = 1'b1;
      #1;
      w = 0;
      while (!op_ready && (w < 100)) begin
         tick();
         w++;
      end
      vectors++;
      assert (w < 100) else begin
         miscompares++;
         $error("FAIL send_timeout: observed wait %0d expected below 100", w);
      end
      @(posedge clk);
      #1;
      op_valid = 1'b0;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      stb_total   = 0;
      rst      = 1'b0;
      op_in    = '0;
      op_valid = 1'b0;
      mode_in  = 2'b00;
      flush    = 1'b0;

      // Reset state
      tick();
      tick();
      chk("rst_mul_ins", mul_ins, 192'(0));
      chk("rst_mul_stb", 192'(mul_stb), 192'(0));
      chk("rst_mode", 192'(mode), 192'(0));
      chk("rst_busy", 192'(busy), 192'(0));
      rst = 1'b1;
      #1;
      chk("rst_op_ready", 192'(op_ready), 192'(1));

      // Mode 00, twelve consecutive operands
      for (int i = 0; i < 11; i++) send(16'h0001 + 16'(i), 2'b00);
      chk("m00_no_early_stb", 192'(mul_stb), 192'(0));
      send(16'h000C, 2'b00);
      chk("m00_stb", 192'(mul_stb), 192'(1));
      exp_word = {16'h000B, 16'h000C, 16'h0009, 16'h000A, 16'h0007, 16'h0008,
                  16'h0005, 16'h0006, 16'h0003, 16'h0004, 16'h0001, 16'h0002};
      chk("m00_word", mul_ins, exp_word);

      // Mode 01, nine operands
      for (int i = 0; i < 9; i++) send(16'h0011 + 16'(i), 2'b01);
      chk("m01_stb", 192'(mul_stb), 192'(1));
      exp_word = {16'h0000, 16'h0019, 16'h0017, 16'h0018, 16'h0000, 16'h0016,
                  16'h0014, 16'h0015, 16'h0000, 16'h0013, 16'h0011, 16'h0012};
      chk("m01_word", mul_ins, exp_word);
      chk("m01_mode", 192'(mode), 192'(2'b01));
      tick();
      chk("m01_stb_one_cycle", 192'(mul_stb), 192'(0));

      // Mode 10, three operands then flush (mode_in ignored while filling)
      send(16'h0A01, 2'b10);
      send(16'h0A02, 2'b11);
      send(16'h0A03, 2'b10);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("m10_flush_stb", 192'(mul_stb), 192'(1));
      exp_word = {16'h0000, 16'h3F80, 16'h0000, 16'h3F80, 16'h3F80, 16'h3F80,
                  16'h0000, 16'h3F80, 16'h0000, 16'h0A03, 16'h0A01, 16'h0A02};
      chk("m10_flush_word", mul_ins, exp_word);
      chk("m10_mode", 192'(mode), 192'(2'b10));

      // Mode 00 issue, then switch to mode 11 with op_valid held
      for (int i = 0; i < 12; i++) send(16'h0C01 + 16'(i), 2'b00);
      chk("sw_issue_stb", 192'(mul_stb), 192'(1));
      op_in    = 16'h1111;
      mode_in  = 2'b11;
      op_valid = 1'b1;
      #1;
      low_cnt = 0;
      while (!op_ready && (low_cnt < 40)) begin
         low_cnt++;
         tick();
      end
      chk("sw_stall_cycles", 192'(low_cnt), 192'(18));
      chk("sw_mode_before", 192'(mode), 192'(2'b00));
      tick();
      op_valid = 1'b0;
      chk("sw_mode_after", 192'(mode), 192'(2'b11));
      for (int i = 0; i < 5; i++) send(16'h1112 + 16'(i), 2'b11);
      chk("m11_stb", 192'(mul_stb), 192'(1));
      exp_word = {16'h0000, 16'h0000, 16'h0000, 16'h1116, 16'h0000, 16'h1115,
                  16'h0000, 16'h1114, 16'h0000, 16'h1113, 16'h1111, 16'h1112};
      chk("m11_word", mul_ins, exp_word);

      // Reset mid-fill discards the partial group
      for (int i = 0; i < 5; i++) send(16'h0E01 + 16'(i), 2'b00);
      chk("mid_busy", 192'(busy), 192'(1));
      rst = 1'b0;
      #1;
      chk("mid_rst_mul_ins", mul_ins, 192'(0));
      chk("mid_rst_stb", 192'(mul_stb), 192'(0));
      chk("mid_rst_busy", 192'(busy), 192'(0));
      tick();
      tick();
      rst = 1'b1;
      stb_base = stb_total;
      for (int i = 0; i < 12; i++) send(16'h0100 + 16'(i), 2'b00);
      chk("post_rst_no_early_stb", 192'(stb_total - stb_base), 192'(0));
      chk("post_rst_stb", 192'(mul_stb), 192'(1));
      exp_word = {16'h010A, 16'h010B, 16'h0108, 16'h0109, 16'h0106, 16'h0107,
                  16'h0104, 16'h0105, 16'h0102, 16'h0103, 16'h0100, 16'h0101};
      chk("post_rst_word", mul_ins, exp_word);

      // Flush with k=0 is ignored and mul_ins holds
      tick();
      stb_base = stb_total;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      tick();
      chk("idle_flush_no_stb", 192'(stb_total - stb_base), 192'(0));
      chk("idle_flush_hold", mul_ins, exp_word);

      // Gaps in op_valid mid-group
      for (int i = 0; i < 12; i++) begin
         send(16'h0201 + 16'(i), 2'b00);
         if (i < 11) begin
            repeat (i % 3) tick();
         end
      end
      chk("gap_no_early_stb", 192'(stb_total - stb_base), 192'(0));
      chk("gap_stb", 192'(mul_stb), 192'(1));
      exp_word = {16'h020B, 16'h020C, 16'h0209, 16'h020A, 16'h0207, 16'h0208,
                  16'h0205, 16'h0206, 16'h0203, 16'h0204, 16'h0201, 16'h0202};
      chk("gap_word", mul_ins, exp_word);

      // Flush together with an acceptance
      send(16'h0301, 2'b00);
      op_in    = 16'h0302;
      op_valid = 1'b1;
      flush    = 1'b1;
      tick();
      op_valid = 1'b0;
      flush    = 1'b0;
      chk("flush_acc_stb", 192'(mul_stb), 192'(1));
      exp_word = {{10{16'h3F80}}, 16'h0301, 16'h0302};
      chk("flush_acc_word", mul_ins, exp_word);

      // Idle after drain
      repeat (20) tick();
      chk("idle_busy", 192'(busy), 192'(0));
      mode_in = 2'b01;
      #1;
      chk("idle_ready_new_mode", 192'(op_ready), 192'(1));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mul_operand_packer_bf16.md
# mul_operand_packer_bf16

Upstream feeder for the six-slot bf16 multiply chain. It accepts a serial stream of bf16 operands with valid/ready and places each operand in a fixed 16-bit lane of a 192-bit `mul_ins` word, using a per-mode lane map. When a group is complete, it issues the word with a one-cycle `mul_stb` and drives the chain's `mode`. It also holds off mode changes until the chain has drained, and it supports flushing a partial group padded with bf16 1.0.

## Interface
- `DRAIN_CYCLES`, 18: cycles after an issue before a different mode may be accepted.
- `PAD_VALUE`, 16'h3F80: bf16 1.0, written into unfilled used lanes on flush.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `op_in`  in  16  bf16 operand.
- `op_valid`  in  1  `op_in` is valid.
- `op_ready`  out  1  packer accepts an operand this cycle (combinational from state).
- `mode_in`  in  2  requested mode for the group that starts with the next accepted operand.
- `flush`  in  1  issue the current partial group, padded.
- `mul_ins`  out  192  packed operands to the chain (registered).
- `mul_stb`  out  1  one-cycle issue strobe (registered).
- `mode`  out  2  mode of the last issued or currently filling group (registered).
- `busy`  out  1  high while k≠0 or dcnt≠0.

## Operation
- Lane numbering: lane 2n+1 = `mul_ins[32n+31:32n+16]` (slot n, a side); lane 2n = `mul_ins[32n+15:32n]` (slot n, b side).
- Lane map, operand k in acceptance order:
  - 00 (N=12): 1,0,3,2,5,4,7,6,9,8,11,10.
  - 01 (N=9): 1,0,2,5,4,6,9,8,10.
  - 10 (N=8): 1,0,2,4,7,6,8,10.
  - 11 (N=6): 1,0,2,4,6,8.
- Lanes not listed for a mode are always 16'h0000.
- Internal state:
  - assembly buffer, 192 bits;
  - operand counter k, 0..11;
  - drain counter dcnt;
  - `mode` register.
- FSM states: EMPTY (k=0), FILL (k>0), DRAIN.
  - EMPTY, `mode_in`==`mode` or dcnt==0: `op_ready`=1. Accepting an operand loads `mode`←`mode_in`, writes lane map[`mode_in`][0], sets k=1 and moves to FILL (or issues directly if N=1, which never happens).
  - EMPTY, `mode_in`≠`mode` and dcnt≠0: go to DRAIN.
  - DRAIN: `op_ready`=0. Return to EMPTY when dcnt==0 or `mode_in`==`mode`.
  - FILL: `op_ready`=1. `mode_in` is ignored. Each accepted operand goes to lane map[`mode`][k], then k++.
- Issue triggers:
  - acceptance of operand k=N-1, or
  - `flush`=1 in FILL.
- Flush padding: every used lane at index ≥ the post-acceptance k gets `PAD_VALUE`.
- Issue actions, all at one clock edge:
  - `mul_ins` ← assembly buffer including the operand accepted in that cycle;
  - `mul_stb` ← 1;
  - buffer ← 0, k ← 0, dcnt ← `DRAIN_CYCLES`, state ← EMPTY.
- `flush` and an acceptance in the same cycle: the operand is included, then padding is applied.
- `flush` in EMPTY or DRAIN is ignored.
- dcnt decrements by 1 every cycle while nonzero, including during FILL. An issue reloads it.
- `mul_ins` holds its value between issues.

## Timing
- Reset (`rst`=0), asynchronously:
  - `mul_ins`=0, `mul_stb`=0, `mode`=2'b00;
  - k=0, dcnt=0, buffer=0, state EMPTY;
  - `busy`=0, `op_ready`=1 once `rst`=1.
- `mul_stb` rises at the edge after the accepting/flush cycle and is high for exactly one cycle. Latency from the last operand to the strobe is 1 cycle.
- Sustained throughput is one operand per cycle. Back-to-back groups of the same mode run with no bubble.
- Mode switch stall: `op_ready` is low until dcnt reaches 0. The first new-mode operand is accepted exactly `DRAIN_CYCLES` cycles after the issue edge. `mode` changes at that acceptance edge.
- Reset mid-fill discards the partial group. No strobe is emitted.

## Test plan
- Mode 00, operands 0x0001..0x000C on consecutive cycles:
  - one cycle after the 12th, `mul_stb`=1 for 1 cycle;
  - `mul_ins` slot0={0x0001,0x0002} … slot5={0x000B,0x000C}.
- Mode 01, operands 0x0011..0x0019:
  - slot0={11,12}, slot1={0000,13}, slot2={14,15}, slot3={0000,16}, slot4={17,18}, slot5={0000,19};
  - `mode`=01.
- Mode 10, 3 operands 0x0A01..0x0A03, then `flush`:
  - slot0={0A01,0A02}, slot1={0000,0A03};
  - lanes 4,7,6,8,10 = 3F80;
  - all others 0000; `mul_stb` pulses.
- Mode 00 issue, then `mode_in`=11 with `op_valid` held:
  - `op_ready`=0 for 18 cycles after the issue edge;
  - first accept on cycle 18; `mode`=11 from then.
- 5 operands in mode 00, then `rst` low for 2 cycles, then 12 operands 0x0100..0x010B:
  - outputs are zero during reset;
  - a single issue containing only the new operands;
  - no strobe before it.
- `flush` with k=0, and `op_valid` gaps mid-group:
  - no strobe from the flush;
  - the group completes correctly with the lane placement unchanged.
